// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor: passive checker of VGA sync timing. Reports lock, sticky timing errors,
// a count of locked frames and a checksum of each frame's active-area pixels.
`timescale 1ns/1ps
module vga_sync_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rgb,
  input  logic        clear_err,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [15:0] frame_csum,
  output logic [3:0]  err
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_SW   = 11'(H_SYNC - 1);
  localparam logic [10:0] H_TO   = 11'(2 * H_TOTAL);
  localparam logic [10:0] H_A0   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_A1   = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_A0   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_A1   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
  localparam logic [10:0] V_SW   = 11'(V_SYNC * H_TOTAL - 1);

  typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} state_t;

  state_t      state, state_nx;
  logic        hs1, hs2, vs1, vs2;
  logic [5:0]  rgb1;
  logic [10:0] h_cnt, vw_cnt;
  logic [9:0]  v_cnt, hf_cnt, hf_total;
  logic [15:0] csum;
  logic        frame_ok, h_fall, h_rise, v_fall, v_rise, timeout, active, pass;
  logic [3:0]  bad, err_new;

  always_comb begin
    h_fall   = hs2 & ~hs1;
    h_rise   = ~hs2 & hs1;
    v_fall   = vs2 & ~vs1;
    v_rise   = ~vs2 & vs1;
    // an hsync fall coincident with the vsync fall closes the ending frame
    hf_total = hf_cnt + {9'b0, h_fall};
    bad      = {v_rise && vw_cnt != V_SW, v_fall && hf_total != V_TOT,
                h_rise && h_cnt != H_SW, h_fall && h_cnt != H_LAST};
    timeout  = h_cnt == H_TO;
    active   = h_cnt >= H_A0 && h_cnt < H_A1 && v_cnt >= V_A0 && v_cnt < V_A1;
    // frame_ok is only ever set by a vsync fall, so it stays low while seeking
    pass     = v_fall && frame_ok && bad == 4'b0 && !timeout;
    err_new  = state == LOCKED ? bad | {3'b0, timeout} : 4'b0;
    state_nx = timeout ? SEEK :
               v_fall ? (pass ? LOCKED : ACQUIRE) :
               (state == LOCKED && bad != 4'b0) ? ACQUIRE : state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1         <= 1'b0;
      hs2         <= 1'b0;
      vs1         <= 1'b0;
      vs2         <= 1'b0;
      rgb1        <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hf_cnt      <= '0;
      vw_cnt      <= '0;
      csum        <= '0;
      frame_ok    <= 1'b0;
      state       <= SEEK;
      locked      <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      frame_csum  <= '0;
      err         <= '0;
    end else begin
      hs1         <= hsync;
      hs2         <= hs1;
      vs1         <= vsync;
      vs2         <= vs1;
      rgb1        <= rgb;
      h_cnt       <= h_fall ? '0 : h_cnt + {10'b0, h_cnt != '1};
      v_cnt       <= v_fall ? '0 : v_cnt + {9'b0, h_fall};
      hf_cnt      <= v_fall ? '0 : hf_cnt + {9'b0, h_fall && hf_cnt != '1};
      vw_cnt      <= v_fall ? '0 : vw_cnt + {10'b0, !vs1 && vw_cnt != '1};
      csum        <= v_fall ? '0 : active ? {csum[14:0], csum[15]} ^ {10'b0, rgb1} : csum;
      frame_ok    <= !timeout && (v_fall || (frame_ok && bad == 4'b0));
      state       <= state_nx;
      locked      <= state_nx == LOCKED;
      frame_done  <= pass;
      frame_count <= frame_count + {15'b0, pass};
      frame_csum  <= pass ? csum : frame_csum;
      err         <= (clear_err ? 4'b0 : err) | err_new;
    end
  end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb_vga_sync_monitor: drives scaled-down VGA frames from a table and scores the verdict
// the monitor gives on each frame at the following vsync fall.
`timescale 1ns/1ps
module tb_vga_sync_monitor;
  localparam int HA = 16, HF = 4, HS = 8, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int HA0 = HS + HB, HA1 = HS + HB + HA, VA0 = VS + VB, VA1 = VS + VB + VA;

  typedef struct {
    string      name;
    int         lines;
    int         bad_line;
    int         line_len;
    int         sync_len;
    int         vs_lines;
    int         rgb_mode;
    bit         clr;
    logic       exp_locked;
    logic       exp_done;
    logic [3:0] exp_err;
  } row_t;

  typedef struct {
    int          due;
    string       name;
    logic        l;
    logic        d;
    logic [3:0]  e;
    logic [15:0] cnt;
    logic [15:0] cs;
  } exp_t;

  logic        clk, rst_n, hsync, vsync, clear_err;
  logic [5:0]  rgb;
  logic        locked, frame_done;
  logic [15:0] frame_count, frame_csum;
  logic [3:0]  err;

  int          n_chk = 0, n_pass = 0, n_done = 0, cyc = 0;
  exp_t        sb[$];
  exp_t        cur;
  logic [15:0] m_csum = 0, m_fcsum = 0, m_count = 0;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .clear_err(clear_err), .locked(locked), .frame_done(frame_done),
    .frame_count(frame_count), .frame_csum(frame_csum), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_chk);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) n_done++;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      cur = sb.pop_front();
      chk({cur.name, "_locked"}, 16'(locked), 16'(cur.l));
      chk({cur.name, "_done"}, 16'(frame_done), 16'(cur.d));
      chk({cur.name, "_err"}, 16'(err), 16'(cur.e));
      chk({cur.name, "_count"}, frame_count, cur.cnt);
      chk({cur.name, "_csum"}, frame_csum, cur.cs);
    end
  end

  function automatic row_t mk(input string n, input int lines, input int bl, input int ll,
                              input int sl, input int vsl, input int mode, input bit clr,
                              input logic el, input logic ed, input logic [3:0] ee);
    row_t r;
    r.name = n; r.lines = lines; r.bad_line = bl; r.line_len = ll; r.sync_len = sl;
    r.vs_lines = vsl; r.rgb_mode = mode; r.clr = clr;
    r.exp_locked = el; r.exp_done = ed; r.exp_err = ee;
    return r;
  endfunction

  task automatic drive(input logic h, input logic v, input logic [5:0] p, input logic c);
    @(negedge clk);
    hsync = h; vsync = v; rgb = p; clear_err = c;
  endtask

  // Pixel column c (hsync falls at c=0) is seen by the monitor with h_cnt = c-1,
  // since h_cnt restarts on the clock after the fall is sampled.
  task automatic frame(input row_t r);
    int         len, sw;
    logic [5:0] p;
    exp_t       e;
    if (r.exp_done) begin
      m_count++;
      m_fcsum = m_csum;
    end
    m_csum = 0;
    for (int l = 0; l < r.lines; l++) begin
      len = (l == r.bad_line) ? r.line_len : HT;
      sw  = (l == r.bad_line) ? r.sync_len : HS;
      for (int c = 0; c < len; c++) begin
        p = r.rgb_mode == 1 ? 6'($urandom_range(0, 63)) :
            (r.rgb_mode == 2 && l == VA1 - 1 && c == HA1) ? 6'h01 : 6'h00;
        drive(c >= sw, l >= r.vs_lines, p, r.clr && l == 1 && c == 5);
        if (l == 0 && c == 0) begin
          e.due = cyc + 2; e.name = r.name; e.l = r.exp_locked; e.d = r.exp_done;
          e.e = r.exp_err; e.cnt = m_count; e.cs = m_fcsum;
          sb.push_back(e);
        end
        if (c >= 1 && c - 1 >= HA0 && c - 1 < HA1 && l >= VA0 && l < VA1)
          m_csum = {m_csum[14:0], m_csum[15]} ^ {10'b0, p};
      end
    end
  endtask

  initial begin
    row_t rows[$];
    rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 6'h00; clear_err = 1'b0;
    // each row: frame to drive, then the verdict on the previous frame at its first vsync fall
    rows.push_back(mk("f0_seek",     VT, -1, HT,     HS,     VS,     0, 0, 0, 0, 4'h0));
    rows.push_back(mk("f1_lock",     VT, -1, HT,     HS,     VS,     0, 0, 1, 1, 4'h0));
    rows.push_back(mk("f2_rand",     VT, -1, HT,     HS,     VS,     1, 0, 1, 1, 4'h0));
    rows.push_back(mk("f3_nom",      VT, -1, HT,     HS,     VS,     0, 0, 1, 1, 4'h0));
    rows.push_back(mk("f4_longline", VT,  5, HT + 1, HS,     VS,     0, 0, 1, 1, 4'h0));
    rows.push_back(mk("f5_htot_err", VT, -1, HT,     HS,     VS,     0, 0, 0, 0, 4'h1));
    rows.push_back(mk("f6_relock",   VT, -1, HT,     HS,     VS,     0, 1, 1, 1, 4'h1));
    rows.push_back(mk("f7_shortsync",VT,  3, HT,     HS - 1, VS,     0, 0, 1, 1, 4'h0));
    rows.push_back(mk("f8_hw_err",   VT, -1, HT,     HS,     VS,     0, 0, 0, 0, 4'h2));
    rows.push_back(mk("f9_relock",   VT, -1, HT,     HS,     VS,     0, 1, 1, 1, 4'h2));
    rows.push_back(mk("f10_short",   VT - 1, -1, HT, HS,     VS,     0, 0, 1, 1, 4'h0));
    rows.push_back(mk("f11_vt_err",  VT, -1, HT,     HS,     VS,     0, 0, 0, 0, 4'h4));
    rows.push_back(mk("f12_relock",  VT, -1, HT,     HS,     VS,     0, 1, 1, 1, 4'h4));
    rows.push_back(mk("f13_lastpix", VT, -1, HT,     HS,     VS,     2, 0, 1, 1, 4'h0));
    rows.push_back(mk("f14_vs_long", VT, -1, HT,     HS,     VS + 1, 0, 0, 1, 1, 4'h0));
    rows.push_back(mk("f15_vw_err",  VT, -1, HT,     HS,     VS,     0, 0, 0, 0, 4'h8));
    rows.push_back(mk("f16_relock",  VT, -1, HT,     HS,     VS,     0, 1, 1, 1, 4'h8));
    rows.push_back(mk("f17_nom",     VT, -1, HT,     HS,     VS,     0, 0, 1, 1, 4'h0));
    repeat (3) @(negedge clk);
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_done", 16'(frame_done), 16'h0);
    chk("rst_count", frame_count, 16'h0);
    chk("rst_csum", frame_csum, 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    rst_n = 1'b1;
    repeat (10) drive(1'b1, 1'b1, 6'h00, 1'b0);
    foreach (rows[i]) frame(rows[i]);
    // hsync stuck high past the 2*H_TOTAL timeout while locked
    repeat (2 * HT + 6) drive(1'b1, 1'b1, 6'h00, 1'b0);
    chk("timeout_locked", 16'(locked), 16'h0);
    chk("timeout_err", 16'(err), 16'h1);
    chk("timeout_count", frame_count, m_count);
    frame(mk("seek_reacq", VT, -1, HT, HS, VS, 0, 0, 0, 0, 4'h1));
    frame(mk("relock_rand", VT, -1, HT, HS, VS, 1, 0, 1, 1, 4'h1));
    frame(mk("partial", 7, -1, HT, HS, VS, 0, 0, 1, 1, 4'h1));
    chk("done_pulses", 16'(n_done), m_count);
    chk("queue_drained", 16'(sb.size()), 16'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_locked", 16'(locked), 16'h0);
    chk("midrst_done", 16'(frame_done), 16'h0);
    chk("midrst_count", frame_count, 16'h0);
    chk("midrst_csum", frame_csum, 16'h0);
    chk("midrst_err", 16'(err), 16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive(1'b1, 1'b1, 6'h00, 1'b0);
    chk("post_rst_locked", 16'(locked), 16'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
